// File: rtl/user_tx_packet_arbiter_if.sv
// Bundle of user-side and layer-side TX stream signals around the packet arbiter.
// Handshake: a word moves when valid and ready are both high in the same cycle; a source holds data/valid/last stable until ready.
interface user_tx_packet_arbiter_if #(
  parameter int NUM_USERS = 4,
  parameter int DATA_W    = 256
);
  localparam int UID_W = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1;

  logic [NUM_USERS*DATA_W-1:0] users_tx_data;
  logic [NUM_USERS-1:0]        users_tx_valid;
  logic [NUM_USERS-1:0]        users_tx_last;
  logic [NUM_USERS-1:0]        users_tx_ready;
  logic [DATA_W-1:0]           layer_tx_data;
  logic                        layer_tx_valid;
  logic                        layer_tx_last;
  logic [UID_W-1:0]            layer_tx_user;
  logic                        controller_packet;
  logic                        layer_tx_ready;

  modport master (
    input  users_tx_data, users_tx_valid, users_tx_last, layer_tx_ready,
    output users_tx_ready, layer_tx_data, layer_tx_valid, layer_tx_last,
           layer_tx_user, controller_packet
  );

  modport slave (
    output users_tx_data, users_tx_valid, users_tx_last, layer_tx_ready,
    input  users_tx_ready, layer_tx_data, layer_tx_valid, layer_tx_last,
           layer_tx_user, controller_packet
  );
endinterface

// File: rtl/user_tx_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one TX channel among NUM_USERS sources,
// with max-length truncation, sticky per-user length errors and a beat counter.
module user_tx_packet_arbiter #(
  parameter int NUM_USERS = 4,
  parameter int DATA_W    = 256,
  parameter int MAX_LINES = 64,
  parameter int CTRL_USER = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  user_tx_packet_arbiter_if.master bus,
  output logic [NUM_USERS-1:0]   user_len_error,
  output logic [19:0]            user_tx_lines,
  output logic [1:0]             fsm_state
);
  localparam int UID_W = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1;
  localparam int CNT_W = $clog2(MAX_LINES + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]           state;
  logic [UID_W-1:0]     grant;
  logic [UID_W-1:0]     last_grant;
  logic [CNT_W-1:0]     beat_cnt;

  logic                 g_valid;
  logic                 g_last;
  logic                 at_max;
  logic                 xfer;
  logic                 drop;
  logic [NUM_USERS-1:0] other_req;
  logic [UID_W-1:0]     idle_winner;
  logic [UID_W-1:0]     busy_winner;

  function automatic logic [UID_W-1:0] next_uid(input logic [UID_W-1:0] u);
    return (u == UID_W'(NUM_USERS - 1)) ? '0 : u + UID_W'(1);
  endfunction

  // First set bit of req, scanning upward from start with wrap.
  function automatic logic [UID_W-1:0] pick(input logic [NUM_USERS-1:0] req,
                                            input logic [UID_W-1:0]     start);
    logic [UID_W-1:0] idx;
    logic [UID_W-1:0] res;
    logic             found;
    idx   = start;
    res   = start;
    found = 1'b0;
    for (int i = 0; i < NUM_USERS; i++) begin
      if (!found && req[idx]) begin
        res   = idx;
        found = 1'b1;
      end
      idx = next_uid(idx);
    end
    return res;
  endfunction

  always_comb begin
    g_valid     = bus.users_tx_valid[grant];
    g_last      = bus.users_tx_last[grant];
    at_max      = (beat_cnt == CNT_W'(MAX_LINES - 1));
    other_req   = bus.users_tx_valid;
    other_req[grant] = 1'b0;
    idle_winner = pick(bus.users_tx_valid, next_uid(last_grant));
    busy_winner = pick(other_req, next_uid(grant));
    xfer        = (state == ST_BUSY) && g_valid && bus.layer_tx_ready;
    drop        = (state == ST_DRAIN) && g_valid;

    bus.users_tx_ready    = '0;
    bus.layer_tx_data     = '0;
    bus.layer_tx_valid    = 1'b0;
    bus.layer_tx_last     = 1'b0;
    bus.controller_packet = 1'b0;
    bus.layer_tx_user     = grant;

    case (state)
      ST_BUSY: begin
        bus.layer_tx_data     = bus.users_tx_data[grant*DATA_W +: DATA_W];
        bus.layer_tx_valid    = g_valid;
        bus.layer_tx_last     = g_last | at_max;
        bus.users_tx_ready[grant] = bus.layer_tx_ready;
        bus.controller_packet = g_valid && (grant == UID_W'(CTRL_USER));
      end
      ST_DRAIN: begin
        bus.users_tx_ready[grant] = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      grant          <= '0;
      last_grant     <= UID_W'(NUM_USERS - 1);
      beat_cnt       <= '0;
      user_len_error <= '0;
      user_tx_lines  <= '0;
    end else begin
      if (xfer) user_tx_lines <= user_tx_lines + 20'd1;
      case (state)
        ST_IDLE: begin
          if (|bus.users_tx_valid) begin
            grant    <= idle_winner;
            state    <= ST_BUSY;
            beat_cnt <= '0;
          end
        end
        ST_BUSY: begin
          if (xfer) begin
            if (g_last) begin
              last_grant <= grant;
              beat_cnt   <= '0;
              // Zero-bubble handover when someone else is waiting.
              if (|other_req) grant <= busy_winner;
              else            state <= ST_IDLE;
            end else if (at_max) begin
              user_len_error[grant] <= 1'b1;
              state                 <= ST_DRAIN;
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (drop && g_last) begin
            last_grant <= grant;
            beat_cnt   <= '0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign fsm_state = state;
endmodule
